// File: rtl/reset_sequencer.sv
// Staged reset sequencer: holds memory/core/peripheral domains in reset, then releases them in order.
// Optional macro RST_SEQ_CAUSE_EN adds a registered reset-cause field; otherwise rst_cause is tied to 2'b00.
module reset_sequencer #(
  parameter int HOLD_CYCLES = 16,
  parameter int STAGE_GAP   = 8,
  parameter int QUIESCE_TO  = 32,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       arst,
  input  logic       sw_rst_req,
  input  logic       wdt_expire,
  input  logic       quiesce_ack,
  output logic       quiesce_req,
  output logic       rst_mem,
  output logic       rst_core,
  output logic       rst_periph,
  output logic       rst_done,
  output logic [1:0] rst_cause,
  output logic [2:0] dbg_state
);

  typedef enum logic [2:0] {
    ST_ASSERT  = 3'd0,
    ST_MEM     = 3'd1,
    ST_CORE    = 3'd2,
    ST_RUN     = 3'd3,
    ST_QUIESCE = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP - 1);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(QUIESCE_TO - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rst_mem_q, rst_core_q, rst_periph_q, rst_done_q, quiesce_req_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ASSERT:  if (cnt_q == HOLD_LAST) state_d = ST_MEM;
      ST_MEM:     if (cnt_q == GAP_LAST)  state_d = ST_CORE;
      ST_CORE:    if (cnt_q == GAP_LAST)  state_d = ST_RUN;
      ST_RUN: begin
        // Watchdog skips the quiesce handshake entirely.
        if (wdt_expire)      state_d = ST_ASSERT;
        else if (sw_rst_req) state_d = ST_QUIESCE;
      end
      ST_QUIESCE: begin
        if (wdt_expire || quiesce_ack || (cnt_q == TO_LAST)) state_d = ST_ASSERT;
      end
      default:    state_d = ST_ASSERT;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q)   cnt_d = '0;
    else if (state_q != ST_RUN) cnt_d = cnt_q + CNT_W'(1);
  end

  // Outputs are registered from the next state so they change on the transition edge.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q       <= ST_ASSERT;
      cnt_q         <= '0;
      rst_mem_q     <= 1'b1;
      rst_core_q    <= 1'b1;
      rst_periph_q  <= 1'b1;
      rst_done_q    <= 1'b0;
      quiesce_req_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      rst_mem_q     <= (state_d == ST_ASSERT);
      rst_core_q    <= (state_d == ST_ASSERT) || (state_d == ST_MEM);
      rst_periph_q  <= (state_d == ST_ASSERT) || (state_d == ST_MEM) || (state_d == ST_CORE);
      rst_done_q    <= (state_d == ST_RUN);
      quiesce_req_q <= (state_d == ST_QUIESCE);
    end
  end

`ifdef RST_SEQ_CAUSE_EN
  logic [1:0] cause_q, cause_d;

  always_comb begin
    cause_d = cause_q;
    case (state_q)
      ST_RUN:     if (wdt_expire) cause_d = 2'b10;
      ST_QUIESCE: begin
        if (wdt_expire)              cause_d = 2'b10;
        else if (quiesce_ack)        cause_d = 2'b01;
        else if (cnt_q == TO_LAST)   cause_d = 2'b11;
      end
      default:    cause_d = cause_q;
    endcase
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) cause_q <= 2'b00;
    else      cause_q <= cause_d;
  end

  assign rst_cause = cause_q;
`else
  assign rst_cause = 2'b00;
`endif

  assign rst_mem     = rst_mem_q;
  assign rst_core    = rst_core_q;
  assign rst_periph  = rst_periph_q;
  assign rst_done    = rst_done_q;
  assign quiesce_req = quiesce_req_q;
  assign dbg_state   = state_q;

endmodule
